// File: rtl/ct_mmu_iplru_arb.sv
// ct_mmu_iplru_arb: round-robin hit-update arbiter and refill sequencer for the iuTLB PLRU.
// Hit update reaches the PLRU 2 cycles after capture; refill request-to-ack is 3 cycles.
// One holding slot per requester (rdy = slot empty); IPLRU_ARB_DUP_DROP_EN drops repeated hits.
module ct_mmu_iplru_arb #(
    parameter int NREQ  = 4,
    parameter int ENTRY = 32
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic [NREQ-1:0]       req_hit_vld,
    input  logic [NREQ*ENTRY-1:0] req_hit,
    output logic [NREQ-1:0]       req_hit_rdy,
    input  logic                  refill_req,
    output logic                  refill_ack,
    output logic [ENTRY-1:0]      refill_entry,
    input  logic [ENTRY-1:0]      plru_iutlb_ref_num,
    output logic [ENTRY-1:0]      utlb_plru_read_hit,
    output logic                  utlb_plru_read_hit_vld,
    output logic                  utlb_plru_refill_on,
    output logic                  utlb_plru_refill_vld,
    output logic                  arb_busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ON, VLD, ACK} state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  slot_vld_q, slot_vld_d;
    logic [ENTRY-1:0] slot_dat_q [NREQ];
    logic [ENTRY-1:0] slot_dat_d [NREQ];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [ENTRY-1:0] hit_q, hit_d;
    logic             hit_vld_q, hit_vld_d;
    logic [ENTRY-1:0] entry_q, entry_d;

    logic             grant_en;
    logic             gnt_found;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    cand;
    logic [ENTRY-1:0] gnt_dat;
    logic             issue;

    // Refill FSM
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (refill_req) state_d = ON;
            ON:      state_d = refill_req ? VLD : IDLE;
            VLD:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        utlb_plru_refill_on  = (state_q == ON) || (state_q == VLD);
        utlb_plru_refill_vld = (state_q == VLD);
        refill_ack           = (state_q == ACK);
    end

    // Grants only in IDLE and never on the cycle a refill is being taken,
    // so a hit update can never overlap the refill window.
    always_comb begin
        grant_en  = (state_q == IDLE) && !refill_req;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (grant_en && !gnt_found && slot_vld_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_dat = slot_dat_q[gnt_idx];
    end

`ifdef IPLRU_ARB_DUP_DROP_EN
    logic [ENTRY-1:0] last_q, last_d;

    assign issue = gnt_found && (gnt_dat != last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == ACK) last_d = '0;
        else if (issue)     last_d = gnt_dat;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) last_q <= '0;
        else        last_q <= last_d;
    end
`else
    assign issue = gnt_found;
`endif

    // Zero reports are consumed without occupying the slot.
    always_comb begin
        slot_vld_d = slot_vld_q;
        for (int i = 0; i < NREQ; i++) begin
            slot_dat_d[i] = slot_dat_q[i];
            if (req_hit_vld[i] && !slot_vld_q[i] && (|req_hit[i*ENTRY +: ENTRY])) begin
                slot_vld_d[i] = 1'b1;
                slot_dat_d[i] = req_hit[i*ENTRY +: ENTRY];
            end
        end
        if (gnt_found) slot_vld_d[gnt_idx] = 1'b0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_found) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        hit_vld_d = issue;
        hit_d     = issue ? gnt_dat : hit_q;
        entry_d   = (state_q == VLD) ? plru_iutlb_ref_num : entry_q;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            slot_vld_q <= '0;
            ptr_q      <= '0;
            hit_q      <= '0;
            hit_vld_q  <= 1'b0;
            entry_q    <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            ptr_q      <= ptr_d;
            hit_q      <= hit_d;
            hit_vld_q  <= hit_vld_d;
            entry_q    <= entry_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        for (int i = 0; i < NREQ; i++) slot_dat_q[i] <= slot_dat_d[i];
    end

    assign req_hit_rdy            = ~slot_vld_q;
    assign utlb_plru_read_hit     = hit_q;
    assign utlb_plru_read_hit_vld = hit_vld_q;
    assign refill_entry           = entry_q;
    assign arb_busy               = (|slot_vld_q) || (state_q != IDLE);

endmodule

// File: tb/tb_ct_mmu_iplru_arb.sv
// Bench for ct_mmu_iplru_arb: cycle table, directed corner sequences, randomized scoreboard run.
module tb_ct_mmu_iplru_arb;
    localparam int NREQ  = 4;
    localparam int ENTRY = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_hit_vld;
    logic [NREQ*ENTRY-1:0] req_hit;
    logic [NREQ-1:0]       req_hit_rdy;
    logic                  refill_req;
    logic                  refill_ack;
    logic [ENTRY-1:0]      refill_entry;
    logic [ENTRY-1:0]      ref_num;
    logic [ENTRY-1:0]      read_hit;
    logic                  read_hit_vld;
    logic                  refill_on;
    logic                  refill_vld;
    logic                  arb_busy;

    always #5 clk = ~clk;

    ct_mmu_iplru_arb #(.NREQ(NREQ), .ENTRY(ENTRY)) dut (
        .forever_cpuclk         (clk),
        .cpurst                 (rst),
        .req_hit_vld            (req_hit_vld),
        .req_hit                (req_hit),
        .req_hit_rdy            (req_hit_rdy),
        .refill_req             (refill_req),
        .refill_ack             (refill_ack),
        .refill_entry           (refill_entry),
        .plru_iutlb_ref_num     (ref_num),
        .utlb_plru_read_hit     (read_hit),
        .utlb_plru_read_hit_vld (read_hit_vld),
        .utlb_plru_refill_on    (refill_on),
        .utlb_plru_refill_vld   (refill_vld),
        .arb_busy               (arb_busy)
    );

    typedef struct {
        logic [3:0]   hv;
        logic [127:0] hit;
        logic         rq;
        logic [31:0]  rn;
        logic [3:0]   rdy;
        logic         vld;
        logic [31:0]  ehit;
        logic         on;
        logic         rfv;
        logic         ack;
        logic [31:0]  ent;
        logic         busy;
    } vec_t;

    vec_t        vt[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] sbq [NREQ][$];
    logic [3:0]  acc, acc_prev;
    logic [31:0] exp_entry;
    logic        prev_rfv;
    logic        ack_seen;
    int          remaining;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] hv, input logic [127:0] hit, input logic rq,
                                input logic [31:0] rn, input logic [3:0] rdy, input logic vld,
                                input logic [31:0] ehit, input logic on, input logic rfv,
                                input logic ack, input logic [31:0] ent, input logic busy);
        vec_t v;
        v.hv = hv; v.hit = hit; v.rq = rq; v.rn = rn; v.rdy = rdy; v.vld = vld;
        v.ehit = ehit; v.on = on; v.rfv = rfv; v.ack = ack; v.ent = ent; v.busy = busy;
        return v;
    endfunction

    // Every issued hit must be a report the bench handed over and not yet seen.
    task automatic match_hit();
        logic hit_found;
        hit_found = 1'b0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < sbq[i].size(); j++)
                if (!hit_found && sbq[i][j] == read_hit) begin
                    sbq[i].delete(j);
                    hit_found = 1'b1;
                end
        chk("rand_hit_known", {31'b0, hit_found}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_hit_vld = '0; req_hit = '0; refill_req = 1'b0; ref_num = '0;
        tick(); tick();
        chk("rst_rdy", {28'b0, req_hit_rdy}, 32'hF);
        chk("rst_vld", {31'b0, read_hit_vld}, 32'd0);
        chk("rst_hit", read_hit, 32'd0);
        chk("rst_on", {31'b0, refill_on}, 32'd0);
        chk("rst_ack", {31'b0, refill_ack}, 32'd0);
        chk("rst_entry", refill_entry, 32'd0);
        chk("rst_busy", {31'b0, arb_busy}, 32'd0);
        rst = 1'b0;

        // Four-way burst, then refill with slots 1 and 3 held, then a zero report.
        vt.push_back(mk(4'hF, {32'h0800_0000, 32'h0004_0000, 32'h0000_0200, 32'h1}, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(4'h0, 128'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 0, 4'b0001, 1, 32'h1, 0, 0, 0, 0, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 0, 4'b0011, 1, 32'h200, 0, 0, 0, 0, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 0, 4'b0111, 1, 32'h4_0000, 0, 0, 0, 0, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 0, 4'b1111, 1, 32'h0800_0000, 0, 0, 0, 0, 0));
        vt.push_back(mk(4'h0, 128'h0, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(4'b1010, {32'h4000_0000, 32'h0, 32'h20, 32'h0}, 1, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(4'h0, 128'h0, 1, 32'h100, 4'b0101, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(4'h0, 128'h0, 1, 32'h100, 4'b0101, 0, 0, 1, 1, 0, 0, 1));
        vt.push_back(mk(4'h0, 128'h0, 1, 32'h0, 4'b0101, 0, 0, 0, 0, 1, 32'h100, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 32'h0, 4'b0101, 0, 0, 0, 0, 0, 32'h100, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 32'h0, 4'b0111, 1, 32'h20, 0, 0, 0, 32'h100, 1));
        vt.push_back(mk(4'h0, 128'h0, 0, 32'h0, 4'b1111, 1, 32'h4000_0000, 0, 0, 0, 32'h100, 0));
        vt.push_back(mk(4'h0, 128'h0, 0, 32'h0, 4'b1111, 0, 0, 0, 0, 0, 32'h100, 0));
        vt.push_back(mk(4'b0001, 128'h0, 0, 32'h0, 4'b1111, 0, 0, 0, 0, 0, 32'h100, 0));
        vt.push_back(mk(4'h0, 128'h0, 0, 32'h0, 4'b1111, 0, 0, 0, 0, 0, 32'h100, 0));
        vt.push_back(mk(4'h0, 128'h0, 0, 32'h0, 4'b1111, 0, 0, 0, 0, 0, 32'h100, 0));

        for (int k = 0; k < vt.size(); k++) begin
            req_hit_vld = vt[k].hv; req_hit = vt[k].hit;
            refill_req = vt[k].rq; ref_num = vt[k].rn;
            chk($sformatf("t%0d_rdy", k), {28'b0, req_hit_rdy}, {28'b0, vt[k].rdy});
            chk($sformatf("t%0d_vld", k), {31'b0, read_hit_vld}, {31'b0, vt[k].vld});
            if (vt[k].vld) chk($sformatf("t%0d_hit", k), read_hit, vt[k].ehit);
            chk($sformatf("t%0d_on", k), {31'b0, refill_on}, {31'b0, vt[k].on});
            chk($sformatf("t%0d_rfv", k), {31'b0, refill_vld}, {31'b0, vt[k].rfv});
            chk($sformatf("t%0d_ack", k), {31'b0, refill_ack}, {31'b0, vt[k].ack});
            chk($sformatf("t%0d_entry", k), refill_entry, vt[k].ent);
            chk($sformatf("t%0d_busy", k), {31'b0, arb_busy}, {31'b0, vt[k].busy});
            tick();
        end

        // Refill aborted in ON while slot 2 waits.
        req_hit_vld = 4'b0100; req_hit = {32'h0, 32'h1000, 64'h0}; refill_req = 1'b0;
        tick();
        req_hit_vld = '0; req_hit = '0; refill_req = 1'b1;
        chk("abort_rdy", {28'b0, req_hit_rdy}, 32'b1011);
        tick();
        chk("abort_on", {31'b0, refill_on}, 32'd1);
        chk("abort_nogrant", {31'b0, read_hit_vld}, 32'd0);
        chk("abort_held", {28'b0, req_hit_rdy}, 32'b1011);
        refill_req = 1'b0;
        tick();
        chk("abort_off", {31'b0, refill_on}, 32'd0);
        chk("abort_no_rfv", {31'b0, refill_vld}, 32'd0);
        chk("abort_no_ack0", {31'b0, refill_ack}, 32'd0);
        tick();
        chk("abort_resume_vld", {31'b0, read_hit_vld}, 32'd1);
        chk("abort_resume_hit", read_hit, 32'h1000);
        chk("abort_no_ack1", {31'b0, refill_ack}, 32'd0);
        tick();
        chk("abort_busy", {31'b0, arb_busy}, 32'd0);

        // Requester 2 repeats 0x10.
        req_hit_vld = 4'b0100; req_hit = {32'h0, 32'h10, 64'h0};
        tick();
        chk("dup_rdy_lo1", {28'b0, req_hit_rdy}, 32'b1011);
        tick();
        chk("dup_vld1", {31'b0, read_hit_vld}, 32'd1);
        chk("dup_hit1", read_hit, 32'h10);
        chk("dup_rdy_hi", {28'b0, req_hit_rdy}, 32'hF);
        tick();
        req_hit_vld = '0; req_hit = '0;
        chk("dup_rdy_lo2", {28'b0, req_hit_rdy}, 32'b1011);
        chk("dup_gap", {31'b0, read_hit_vld}, 32'd0);
        tick();
`ifdef IPLRU_ARB_DUP_DROP_EN
        chk("dup_vld2", {31'b0, read_hit_vld}, 32'd0);
`else
        chk("dup_vld2", {31'b0, read_hit_vld}, 32'd1);
`endif
        chk("dup_hit2", read_hit, 32'h10);
        tick();
        chk("dup_end_vld", {31'b0, read_hit_vld}, 32'd0);
        chk("dup_end_busy", {31'b0, arb_busy}, 32'd0);

        // Reset landing in the VLD cycle.
        req_hit_vld = 4'b0010; req_hit = {64'h0, 32'h8, 32'h0}; refill_req = 1'b1; ref_num = 32'h8000;
        tick();
        req_hit_vld = '0; req_hit = '0;
        chk("rstv_on", {31'b0, refill_on}, 32'd1);
        chk("rstv_rdy", {28'b0, req_hit_rdy}, 32'b1101);
        tick();
        chk("rstv_rfv", {31'b0, refill_vld}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; refill_req = 1'b0;
        chk("rstv_rdy_after", {28'b0, req_hit_rdy}, 32'hF);
        chk("rstv_on_after", {31'b0, refill_on}, 32'd0);
        chk("rstv_rfv_after", {31'b0, refill_vld}, 32'd0);
        chk("rstv_ack_after", {31'b0, refill_ack}, 32'd0);
        chk("rstv_entry_after", refill_entry, 32'd0);
        chk("rstv_busy_after", {31'b0, arb_busy}, 32'd0);
        chk("rstv_vld_after", {31'b0, read_hit_vld}, 32'd0);
        ack_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            ack_seen = ack_seen | refill_ack;
        end
        chk("rstv_no_ack", {31'b0, ack_seen}, 32'd0);

        // Randomized traffic against a scoreboard of handed-over reports.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_prev = '0; exp_entry = '0; prev_rfv = 1'b0;
        for (int cyc = 0; cyc < 3020; cyc++) begin
            if (read_hit_vld) match_hit();
            chk("rand_excl", {31'b0, read_hit_vld & refill_on}, 32'd0);
            chk("rand_ack_seq", {31'b0, refill_ack & ~prev_rfv}, 32'd0);
            chk("rand_entry", refill_entry, exp_entry);
            prev_rfv = refill_vld;
            for (int i = 0; i < NREQ; i++) begin
                if (cyc >= 3000) begin
                    req_hit_vld[i] = 1'b0;
                end else if (!req_hit_vld[i] || acc_prev[i]) begin
                    req_hit_vld[i] = ($urandom_range(0, 2) == 0);
                    req_hit[i*ENTRY +: ENTRY] = ($urandom_range(0, 9) == 0) ? 32'h0
                                                : (32'h1 << $urandom_range(0, 31));
                end
                acc[i] = req_hit_vld[i] & req_hit_rdy[i];
                if (acc[i] && req_hit[i*ENTRY +: ENTRY] != 32'h0)
                    sbq[i].push_back(req_hit[i*ENTRY +: ENTRY]);
            end
            acc_prev = acc;
            if (cyc >= 3000 || refill_ack) refill_req = 1'b0;
            else if (refill_req) refill_req = ($urandom_range(0, 15) != 0);
            else refill_req = ($urandom_range(0, 11) == 0);
            ref_num = 32'h1 << $urandom_range(0, 31);
            if (refill_vld) exp_entry = ref_num;
            tick();
        end
        chk("drain_busy", {31'b0, arb_busy}, 32'd0);
`ifndef IPLRU_ARB_DUP_DROP_EN
        remaining = 0;
        for (int i = 0; i < NREQ; i++) remaining += sbq[i].size();
        chk("drain_empty", remaining, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ct_mmu_iplru_arb.md
# ct_mmu_iplru_arb

Update arbiter and refill sequencer in front of `ct_mmu_iplru`, the 32-entry instruction uTLB pseudo-LRU.
- Collects hit reports from `NREQ` independent lookup requesters and serialises them onto the PLRU's single hit-update port with round-robin fairness.
- Runs the `refill_on` / `refill_vld` sequence for uTLB refills and returns the victim entry to the refill engine.
- Guarantees a hit update and a refill never reach the PLRU in the same cycle.

## Interface
Parameters:
- `NREQ`, 4, number of hit-report requesters (2..8).
- `ENTRY`, 32, uTLB entry count; width of every one-hot vector.

Ports:
- `forever_cpuclk`  in  1  — single clock.
- `cpurst`  in  1  — reset; synchronous, active-high.
- `req_hit_vld`  in  NREQ  — per-requester hit report valid.
- `req_hit`  in  NREQ*ENTRY  — hit vectors; slice i = bits [(i+1)*ENTRY-1 : i*ENTRY]; each slice is one-hot or zero.
- `req_hit_rdy`  out  NREQ  — requester i may present a report.
- `refill_req`  in  1  — refill engine request; level, held until ack.
- `refill_ack`  out  1  — one-cycle pulse; `refill_entry` valid.
- `refill_entry`  out  ENTRY  — captured one-hot victim.
- `plru_iutlb_ref_num`  in  ENTRY  — victim from PLRU.
- `utlb_plru_read_hit`  out  ENTRY  — hit vector to PLRU.
- `utlb_plru_read_hit_vld`  out  1  — hit update valid.
- `utlb_plru_refill_on`  out  1  — refill window to PLRU.
- `utlb_plru_refill_vld`  out  1  — refill commit to PLRU.
- `arb_busy`  out  1  — any slot occupied or FSM not IDLE.

## Operation
Requester slots:
- Each requester has one holding slot. `req_hit_rdy[i]` is 1 when slot i is empty; its value is registered.
- A report is captured when `req_hit_vld[i] & req_hit_rdy[i]`.
- An all-zero slice is accepted and discarded; no slot is occupied.

Arbitration:
- In `IDLE` only, the arbiter grants the first occupied slot at or after pointer `ptr`.
- On a grant, `ptr <= (grant+1) mod NREQ`, the slot is freed, and next cycle `utlb_plru_read_hit <= slot` with `_vld = 1`.
- At most one grant per cycle. `_vld` is low whenever no grant occurred.

Refill FSM, states `IDLE → ON → VLD → ACK → IDLE`:
- `IDLE`: `refill_req = 1` → `ON`. Refill wins over pending hits; no grant is made on that cycle.
- `ON`: `refill_on = 1`; grants suppressed; slots keep accepting until full. If `refill_req` drops here → `IDLE`, with no `refill_vld` and no ack (abort).
- `VLD`: `refill_on = 1`, `refill_vld = 1`; `refill_entry <= plru_iutlb_ref_num`.
- `ACK`: `refill_ack = 1`, `refill_on = 0`; → `IDLE`. `refill_req` is ignored in `ACK`, which forces at least one `IDLE` cycle between refills.

Invariants:
- `utlb_plru_read_hit_vld` and `utlb_plru_refill_on` are never both 1.
- `refill_entry` holds its value until the next `VLD`.

## Timing
- Reset: all outputs 0 except `req_hit_rdy` = all-ones (all slots empty); slots cleared; `ptr = 0`; FSM `IDLE`.
- Reset asserted mid-refill abandons the refill; no ack is issued.
- Hit latency, idle arbiter:
  - Report sampled at edge E.
  - Granted in the cycle after E.
  - `utlb_plru_read_hit_vld` high in the following cycle (2 cycles after presentation).
  - `req_hit_rdy[i]` high again one cycle after the grant.
- Refill:
  - `refill_on` rises 1 cycle after `refill_req` is sampled in `IDLE`.
  - `refill_vld` follows 1 cycle later.
  - `refill_ack` follows 1 cycle after that.
  - Minimum request-to-ack: 3 cycles.
- Throughput: 1 hit update per cycle. With all NREQ slots full and no refill, all NREQ are drained in NREQ consecutive cycles, in pointer order.

## Configuration
- `IPLRU_ARB_DUP_DROP_EN` defined:
  - A register holds the last issued hit vector; reset 0; cleared at `ACK`.
  - A granted slot equal to this register is freed, but no `_vld` is emitted and `ptr` still advances.
  - Rationale: a repeated hit does not change PLRU state.
- Undefined: every accepted non-zero report is issued exactly once.

## Test plan
- After reset, all 4 requesters present `1<<0`, `1<<9`, `1<<18`, `1<<27` in one cycle → `_vld` on 4 consecutive cycles with vectors in order 0, 9, 18, 27; `ptr` ends at 0; `arb_busy` then drops to 0.
- `refill_req` asserted while slots 1 and 3 are full and `plru_iutlb_ref_num = 32'h0000_0100` → `refill_on` 2 cycles, `refill_vld` 1 cycle, `refill_entry = 32'h100`, `refill_ack` 1 cycle; the held hits issue only after `ACK`, slot 1 then slot 3; no overlap with `refill_on`.
- `refill_req` dropped during `ON` → no `refill_vld`, no `refill_ack`, FSM returns to `IDLE`, pending hits resume.
- Requester 2 sends `32'h10` twice back-to-back → with `IPLRU_ARB_DUP_DROP_EN`, exactly one `_vld`; without it, two, one cycle apart; `req_hit_rdy[2]` low the cycle after each capture.
- All-zero report on requester 0 → no slot occupied, no `_vld`, `req_hit_rdy[0]` stays 1.
- `cpurst` asserted in the `VLD` cycle → next cycle all outputs 0, `req_hit_rdy = 4'hF`, no `refill_ack` ever emitted.
